// File: rtl/disp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : disp_share_arb
//  Brief    : Round-robin, dwell-preempting arbiter that shares one 4-digit
//             seven-segment display between two clients.
//  Revision : 1.0 - initial release
// ============================================================================
module disp_share_arb #(
    parameter int          DWELL_CYC = 50_000_000,
    parameter int          CNT_W     = 26,
    parameter logic [15:0] IDLE_HEX  = 16'h0000,
    parameter logic [3:0]  IDLE_DP   = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [3:0]  dp0,
    input  logic [3:0]  dp1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_out
);

    localparam logic [0:0]       c_S_IDLE  = 1'b0;
    localparam logic [0:0]       c_S_SHOW  = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DWELL_CYC - 1);

    logic [0:0]       r_state;
    logic             r_lp;     // last owner; equals the current owner in SHOW
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [15:0]      r_hex;
    logic [3:0]       r_dp;

    logic             w_pick;
    logic             w_other;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_slot_end;
    logic [15:0]      w_val_pick;
    logic [3:0]       w_dp_pick;
    logic [15:0]      w_val_own;
    logic [3:0]       w_dp_own;
    logic [15:0]      w_val_oth;
    logic [3:0]       w_dp_oth;

    always_comb begin
        w_pick     = (req == 2'b11) ? ~r_lp : req[1];
        w_other    = ~r_lp;
        w_own_req  = req[r_lp];
        w_oth_req  = req[w_other];
        w_slot_end = ~w_own_req | ((r_cnt == c_CNT_MAX) & w_oth_req);
        w_val_pick = w_pick  ? val1 : val0;
        w_dp_pick  = w_pick  ? dp1  : dp0;
        w_val_own  = r_lp    ? val1 : val0;
        w_dp_own   = r_lp    ? dp1  : dp0;
        w_val_oth  = w_other ? val1 : val0;
        w_dp_oth   = w_other ? dp1  : dp0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_lp    <= 1'b1;
            r_cnt   <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_hex   <= IDLE_HEX;
            r_dp    <= IDLE_DP;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                c_S_IDLE: begin
                    if (req != 2'b00) begin
                        r_state <= c_S_SHOW;
                        r_lp    <= w_pick;
                        r_cnt   <= '0;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_hex   <= w_val_pick;
                        r_dp    <= w_dp_pick;
                    end else begin
                        r_hex   <= IDLE_HEX;
                        r_dp    <= IDLE_DP;
                    end
                end
                default: begin
                    if (w_slot_end) begin
                        r_done <= r_lp ? 2'b10 : 2'b01;
                        if (w_oth_req) begin
                            // Direct handoff: gnt flips without an idle gap
                            r_lp  <= w_other;
                            r_cnt <= '0;
                            r_gnt <= w_other ? 2'b10 : 2'b01;
                            r_hex <= w_val_oth;
                            r_dp  <= w_dp_oth;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_gnt   <= 2'b00;
                            r_hex   <= IDLE_HEX;
                            r_dp    <= IDLE_DP;
                        end
                    end else begin
                        if (r_cnt != c_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_hex <= w_val_own;
                        r_dp  <= w_dp_own;
                    end
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign hex3   = r_hex[15:12];
    assign hex2   = r_hex[11:8];
    assign hex1   = r_hex[7:4];
    assign hex0   = r_hex[3:0];
    assign dp_out = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_disp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_share_arb
//  Brief    : Scoreboard bench for disp_share_arb with DWELL_CYC=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disp_share_arb;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic [15:0] hex;
        logic [3:0]  dp;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] val0, val1;
    logic [3:0]  dp0, dp1;
    logic [1:0]  gnt, done;
    logic [3:0]  hex3, hex2, hex1, hex0, dp_out;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    localparam logic [15:0] c_V0 = 16'h1111;
    localparam logic [15:0] c_V1 = 16'h2222;
    localparam logic [3:0]  c_D0 = 4'b0001;
    localparam logic [3:0]  c_D1 = 4'b0010;
    localparam logic [15:0] c_IH = 16'h0000;
    localparam logic [3:0]  c_ID = 4'b1111;

    disp_share_arb #(
        .DWELL_CYC (8),
        .CNT_W     (4),
        .IDLE_HEX  (16'h0000),
        .IDLE_DP   (4'b1111)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .val0   (val0),
        .val1   (val1),
        .dp0    (dp0),
        .dp1    (dp1),
        .gnt    (gnt),
        .done   (done),
        .hex3   (hex3),
        .hex2   (hex2),
        .hex1   (hex1),
        .hex0   (hex0),
        .dp_out (dp_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic rst_i, input logic [1:0] rq,
                        input logic [1:0] eg, input logic [1:0] ed,
                        input logic [15:0] eh, input logic [3:0] edp,
                        input string tag);
        exp_t e;
        reset = rst_i;
        req   = rq;
        e.gnt = eg; e.done = ed; e.hex = eh; e.dp = edp; e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (gnt !== e.gnt || done !== e.done ||
                    {hex3, hex2, hex1, hex0} !== e.hex || dp_out !== e.dp) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b done=%b hex=%h dp=%b, want gnt=%b done=%b hex=%h dp=%b",
                             e.tag, gnt, done, {hex3, hex2, hex1, hex0}, dp_out,
                             e.gnt, e.done, e.hex, e.dp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req = 2'b00;
        val0 = c_V0; val1 = c_V1; dp0 = c_D0; dp1 = c_D1;

        step(1, 2'b00, 2'b00, 2'b00, c_IH, c_ID, "reset");
        for (int i = 0; i < 10; i++) step(0, 2'b00, 2'b00, 2'b00, c_IH, c_ID, "idle_hold");

        // Single client with live data tracking
        val0 = 16'h1234; dp0 = 4'b1110;
        step(0, 2'b01, 2'b01, 2'b00, 16'h1234, 4'b1110, "single_grant");
        step(0, 2'b01, 2'b01, 2'b00, 16'h1234, 4'b1110, "single_hold");
        val0 = 16'hBEEF;
        step(0, 2'b01, 2'b01, 2'b00, 16'hBEEF, 4'b1110, "live_track");
        val1 = 16'h5A5A;
        step(0, 2'b01, 2'b01, 2'b00, 16'hBEEF, 4'b1110, "other_val_ignored");
        step(0, 2'b00, 2'b00, 2'b01, c_IH, c_ID, "single_release");
        step(0, 2'b00, 2'b00, 2'b00, c_IH, c_ID, "done_one_cycle");

        // Tie after reset, dwell preemption both ways
        val0 = c_V0; val1 = c_V1; dp0 = c_D0; dp1 = c_D1;
        step(1, 2'b00, 2'b00, 2'b00, c_IH, c_ID, "reset2");
        for (int i = 0; i < 8; i++) step(0, 2'b11, 2'b01, 2'b00, c_V0, c_D0, "tie_c0_slot");
        for (int i = 0; i < 8; i++)
            step(0, 2'b11, 2'b10, (i == 0) ? 2'b01 : 2'b00, c_V1, c_D1, "preempt_to_c1");
        step(0, 2'b11, 2'b01, 2'b10, c_V0, c_D0, "preempt_back_c0");
        step(0, 2'b00, 2'b00, 2'b01, c_IH, c_ID, "tie_release");
        step(0, 2'b00, 2'b00, 2'b00, c_IH, c_ID, "tie_idle");

        // Lone client never preempted
        for (int i = 0; i < 100; i++) step(0, 2'b10, 2'b10, 2'b00, c_V1, c_D1, "no_contention");
        step(0, 2'b00, 2'b00, 2'b10, c_IH, c_ID, "lone_release");

        // Handoff on release before the dwell expires
        for (int i = 0; i < 4; i++) step(0, 2'b01, 2'b01, 2'b00, c_V0, c_D0, "ho_c0_cnt0_3");
        step(0, 2'b11, 2'b01, 2'b00, c_V0, c_D0, "ho_c0_cnt4");
        step(0, 2'b11, 2'b01, 2'b00, c_V0, c_D0, "ho_c0_cnt5");
        step(0, 2'b10, 2'b10, 2'b01, c_V1, c_D1, "handoff_release");
        step(0, 2'b10, 2'b10, 2'b00, c_V1, c_D1, "handoff_hold");

        // Reset mid-slot, then client 0 wins the tie again
        step(1, 2'b10, 2'b00, 2'b00, c_IH, c_ID, "reset_mid_slot");
        step(0, 2'b11, 2'b01, 2'b00, c_V0, c_D0, "tie_after_reset");
        step(0, 2'b00, 2'b00, 2'b01, c_IH, c_ID, "final_release");
        step(0, 2'b00, 2'b00, 2'b00, c_IH, c_ID, "final_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
